// File: rtl/odd_parity_checker_serial.sv
// Serial odd-parity frame receiver: start bit, DATA_W data bits LSB first, odd parity bit, stop bit.
// Reports each completed frame with a one-cycle done strobe plus parity and framing error flags.
module odd_parity_checker_serial #(
    parameter int DATA_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_bit,
    output logic [DATA_W-1:0] data_out,
    output logic              done,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [DATA_W:0]   r_shift;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_par;
    logic [DATA_W-1:0] r_data_out;
    logic              r_done;
    logic              r_parity_err;
    logic              r_frame_err;
    logic              w_last_data;

    assign w_last_data = (r_cnt == CNT_W'(DATA_W - 1));

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: next state defaults to the current state first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        if (in_valid) begin
            unique case (r_state)
                IDLE:    if (!in_bit) w_next_state = DATA;
                DATA:    if (w_last_data) w_next_state = PARITY;
                PARITY:  w_next_state = STOP;
                STOP:    w_next_state = IDLE;
                default: w_next_state = IDLE;
            endcase
        end
    end

    // The shift register is one bit wider than the word so the shift slice stays legal for DATA_W=1;
    // after DATA_W shifts the received word sits in r_shift[DATA_W:1].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift      <= '0;
            r_cnt        <= '0;
            r_par        <= 1'b0;
            r_data_out   <= '0;
            r_done       <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (in_valid) begin
                unique case (r_state)
                    IDLE: begin
                        if (!in_bit) begin
                            r_shift <= '0;
                            r_cnt   <= '0;
                            r_par   <= 1'b0;
                        end
                    end
                    DATA: begin
                        r_shift <= {in_bit, r_shift[DATA_W:1]};
                        r_cnt   <= r_cnt + CNT_W'(1);
                        r_par   <= r_par ^ in_bit;
                    end
                    PARITY: begin
                        r_par <= r_par ^ in_bit;
                    end
                    STOP: begin
                        r_data_out   <= r_shift[DATA_W:1];
                        r_parity_err <= ~r_par;
                        r_frame_err  <= ~in_bit;
                        r_done       <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign data_out   = r_data_out;
    assign done       = r_done;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_odd_parity_checker_serial.sv
// Scoreboard bench for odd_parity_checker_serial: the driver pushes expected frame results,
// a negedge monitor pops and compares on every done pulse.
module tb_odd_parity_checker_serial;

    localparam int DATA_W = 3;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              perr;
        logic              ferr;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_bit;
    logic [DATA_W-1:0] data_out;
    logic              done;
    logic              parity_err;
    logic              frame_err;
    logic              busy;

    int   checks      = 0;
    int   failures    = 0;
    int   done_count  = 0;
    int   frames_sent = 0;
    logic prev_done   = 1'b0;
    exp_t exp_q[$];

    odd_parity_checker_serial #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .data_out  (data_out),
        .done      (done),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expected frame.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                done_count++;
                check("done_single_cycle", {31'd0, prev_done}, 32'd0);
                if (exp_q.size() == 0) begin
                    check("done_unexpected", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("data_out", {29'd0, data_out}, {29'd0, e.data});
                    check("parity_err", {31'd0, parity_err}, {31'd0, e.perr});
                    check("frame_err", {31'd0, frame_err}, {31'd0, e.ferr});
                end
            end
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    // One accepted bit, preceded by `gap` stalled cycles.
    task automatic drive_bit(input logic b, input int gap);
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_bit   = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_bit   = 1'b1;
    endtask

    // Reference model: odd parity means data ones plus parity bit must total an odd count.
    task automatic send_frame(input logic [DATA_W-1:0] data, input logic par, input logic stop,
                              input int min_gap, input int max_gap);
        exp_t e;
        e.data = data;
        e.perr = ((($countones(data) + int'(par)) % 2) == 0);
        e.ferr = (stop == 1'b0);
        drive_bit(1'b0, $urandom_range(max_gap, min_gap));
        check("busy_in_frame", {31'd0, busy}, 32'd1);
        for (int i = 0; i < DATA_W; i++) drive_bit(data[i], $urandom_range(max_gap, min_gap));
        drive_bit(par, $urandom_range(max_gap, min_gap));
        exp_q.push_back(e);
        frames_sent++;
        drive_bit(stop, $urandom_range(max_gap, min_gap));
    endtask

    initial begin
        int base_done;
        in_valid = 1'b0;
        in_bit   = 1'b1;
        rst_n    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_data", {29'd0, data_out}, 32'd0);
        rst_n = 1'b1;

        // Idle line: ten valid 1s never start a frame.
        for (int i = 0; i < 10; i++) begin
            drive_bit(1'b1, 0);
            check("idle_busy", {31'd0, busy}, 32'd0);
            check("idle_done", {31'd0, done}, 32'd0);
            check("idle_outs", {29'd0, data_out, parity_err, frame_err}, 32'd0);
        end

        send_frame(3'b101, 1'b1, 1'b1, 0, 0);
        send_frame(3'b101, 1'b0, 1'b1, 0, 0);
        send_frame(3'b000, 1'b1, 1'b1, 0, 0);
        send_frame(3'b111, 1'b0, 1'b0, 0, 0);
        // Bit right after the bad stop bit is taken as the next start bit.
        send_frame(3'b010, 1'b0, 1'b1, 0, 0);
        send_frame(3'b110, 1'b1, 1'b1, 1, 3);
        repeat (3) begin
            @(posedge clk);
            #1;
        end

        // Asynchronous reset in the middle of a frame discards it.
        base_done = done_count;
        drive_bit(1'b0, 0);
        drive_bit(1'b1, 0);
        drive_bit(1'b1, 0);
        check("mid_frame_busy", {31'd0, busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        check("async_rst_outs", {29'd0, data_out, parity_err, frame_err}, 32'd0);
        check("async_rst_done", {31'd0, done}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check("no_done_after_rst", done_count, base_done);
        check("busy_after_rst", {31'd0, busy}, 32'd0);

        send_frame(3'b011, 1'b1, 1'b1, 0, 1);

        for (int n = 0; n < 40; n++) begin
            logic [DATA_W-1:0] d;
            logic              p;
            logic              s;
            d = DATA_W'($urandom);
            p = 1'($urandom);
            s = ($urandom_range(3, 0) != 0);
            send_frame(d, p, s, 0, ($urandom_range(1, 0) == 1) ? 2 : 0);
        end

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check("scoreboard_drained", exp_q.size(), 32'd0);
        check("done_count", done_count, frames_sent);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
